// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: turns debounced key events into the snake's movement
// direction and a run/pause/game-over control state. Direction requests are
// held in a small circular queue and applied one per movement step. Requests
// that would reverse the snake into its own body are dropped.
module snake_dir_ctrl #(
  parameter int         Q_DEPTH  = 2,
  parameter logic [1:0] INIT_DIR = 2'd3
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [4:0] key_flag,
  input  logic [4:0] key_value,
  input  logic       step_tick,
  input  logic       game_over,
  output logic [1:0] dir,
  output logic       run,
  output logic       dir_changed,
  output logic [2:0] q_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam logic [2:0] DEPTH    = 3'(Q_DEPTH);
  localparam logic [1:0] LAST_PTR = 2'(Q_DEPTH - 1);

  state_t     state;
  // Storage is sized for the largest legal depth; only the first Q_DEPTH
  // entries are ever addressed because the pointers wrap at LAST_PTR.
  logic [1:0] q_mem [4];
  logic [1:0] rd_ptr;
  logic [1:0] wr_ptr;

  logic [4:0] press;
  logic       start_press;
  logic       req_valid;
  logic [1:0] req_dir;
  logic [1:0] tail_ptr;
  logic [1:0] ref_dir;
  logic       req_ok;
  logic       do_pop;
  logic       do_push;

  // A key event counts as a press only when its level reads "pressed".
  assign press       = key_flag & ~key_value;
  assign start_press = press[4];

  // Advance a queue pointer, wrapping after the last used slot.
  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    return (p == LAST_PTR) ? 2'd0 : p + 2'd1;
  endfunction

  // Pick one direction request per cycle, lowest key index first.
  always_comb begin
    req_valid = |press[3:0];
    req_dir   = 2'd0;
    if (press[0])      req_dir = 2'd0;
    else if (press[1]) req_dir = 2'd1;
    else if (press[2]) req_dir = 2'd2;
    else if (press[3]) req_dir = 2'd3;
  end

  // Judge the request against the direction the snake will have once
  // everything already queued has been applied, and decide pop/push.
  always_comb begin
    tail_ptr = (wr_ptr == 2'd0) ? LAST_PTR : wr_ptr - 2'd1;
    ref_dir  = (q_count != 3'd0) ? q_mem[tail_ptr] : dir;
    req_ok   = req_valid && (req_dir != ref_dir) && (req_dir != (ref_dir ^ 2'd1));
    do_pop   = step_tick && (q_count != 3'd0);
    do_push  = req_ok && ((q_count < DEPTH) || do_pop);
  end

  // Control FSM with registered outputs and the direction queue.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      dir         <= INIT_DIR;
      run         <= 1'b0;
      dir_changed <= 1'b0;
      q_count     <= 3'd0;
      rd_ptr      <= 2'd0;
      wr_ptr      <= 2'd0;
      for (int i = 0; i < 4; i++) q_mem[i] <= 2'd0;
    end else begin
      dir_changed <= 1'b0;
      case (state)
        IDLE: begin
          if (start_press) begin
            state   <= RUN;
            run     <= 1'b1;
            dir     <= INIT_DIR;
            q_count <= 3'd0;
            rd_ptr  <= 2'd0;
            wr_ptr  <= 2'd0;
          end
        end
        RUN: begin
          if (game_over) begin
            state <= OVER;
            run   <= 1'b0;
          end else if (start_press) begin
            state <= PAUSE;
            run   <= 1'b0;
          end else begin
            if (do_pop) begin
              dir         <= q_mem[rd_ptr];
              dir_changed <= 1'b1;
              rd_ptr      <= ptr_next(rd_ptr);
            end
            if (do_push) begin
              q_mem[wr_ptr] <= req_dir;
              wr_ptr        <= ptr_next(wr_ptr);
            end
            q_count <= q_count + {2'b00, do_push} - {2'b00, do_pop};
          end
        end
        PAUSE: begin
          if (game_over) begin
            state <= OVER;
          end else if (start_press) begin
            state <= RUN;
            run   <= 1'b1;
          end
        end
        OVER: begin
          if (start_press) begin
            state   <= IDLE;
            dir     <= INIT_DIR;
            q_count <= 3'd0;
            rd_ptr  <= 2'd0;
            wr_ptr  <= 2'd0;
          end
        end
        default: begin
          state <= IDLE;
          run   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// tb_snake_dir_ctrl: directed test of snake_dir_ctrl against a queue-based
// behavioural model, plus hand-computed expectations at each step.
module tb_snake_dir_ctrl;

  localparam int         Q_DEPTH  = 2;
  localparam logic [1:0] INIT_DIR = 2'd3;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_OVER  = 3;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic [4:0] key_flag  = 5'b00000;
  logic [4:0] key_value = 5'b11111;
  logic       step_tick = 1'b0;
  logic       game_over = 1'b0;
  logic [1:0] dir;
  logic       run;
  logic       dir_changed;
  logic [2:0] q_count;

  int n_vec = 0;
  int n_err = 0;

  int m_state = M_IDLE;
  int m_dir   = 3;
  int m_q[$];
  int m_chg   = 0;

  snake_dir_ctrl #(.Q_DEPTH(Q_DEPTH), .INIT_DIR(INIT_DIR)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .key_flag   (key_flag),
    .key_value  (key_value),
    .step_tick  (step_tick),
    .game_over  (game_over),
    .dir        (dir),
    .run        (run),
    .dir_changed(dir_changed),
    .q_count    (q_count)
  );

  always #10 sys_clk = ~sys_clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Game rules applied to one clock edge, in terms of a plain request list.
  task automatic model_step();
    int  req;
    bit  start;
    int  ref_d;
    req   = -1;
    start = key_flag[4] && !key_value[4];
    for (int i = 0; i < 4; i++)
      if (req < 0 && key_flag[i] && !key_value[i]) req = i;
    m_chg = 0;
    case (m_state)
      M_IDLE: if (start) begin m_state = M_RUN; m_dir = INIT_DIR; m_q.delete(); end
      M_RUN: begin
        if (game_over) m_state = M_OVER;
        else if (start) m_state = M_PAUSE;
        else begin
          ref_d = (m_q.size() > 0) ? m_q[$] : m_dir;
          if (step_tick && m_q.size() > 0) begin
            m_dir = m_q.pop_front();
            m_chg = 1;
          end
          if (req >= 0 && req != ref_d && req != (ref_d ^ 1) && m_q.size() < Q_DEPTH)
            m_q.push_back(req);
        end
      end
      M_PAUSE: begin
        if (game_over) m_state = M_OVER;
        else if (start) m_state = M_RUN;
      end
      default: if (start) begin m_state = M_IDLE; m_dir = INIT_DIR; m_q.delete(); end
    endcase
  endtask

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_state = M_IDLE;
      m_dir   = INIT_DIR;
      m_q.delete();
      m_chg   = 0;
    end else begin
      model_step();
    end
  end

  // Compare every output against the model midway between active edges.
  always @(negedge sys_clk) begin
    checkOutput("model.dir", int'(dir), m_dir);
    checkOutput("model.run", int'(run), (m_state == M_RUN) ? 1 : 0);
    checkOutput("model.dir_changed", int'(dir_changed), m_chg);
    checkOutput("model.q_count", int'(q_count), m_q.size());
  end

  task automatic expect_out(input string tag, input int d, input int r, input int c, input int q);
    checkOutput({tag, ".dir"}, int'(dir), d);
    checkOutput({tag, ".run"}, int'(run), r);
    checkOutput({tag, ".dir_changed"}, int'(dir_changed), c);
    checkOutput({tag, ".q_count"}, int'(q_count), q);
  endtask

  // Drive one cycle of inputs from a negedge; returns at the next negedge.
  task automatic applyStimulus(input logic [4:0] flag, input logic [4:0] val,
                               input logic tick, input logic go);
    key_flag  = flag;
    key_value = val;
    step_tick = tick;
    game_over = go;
    @(negedge sys_clk);
    key_flag  = 5'b00000;
    key_value = 5'b11111;
    step_tick = 1'b0;
    game_over = 1'b0;
  endtask

  task automatic press(input int idx, input logic tick);
    logic [4:0] m;
    m = 5'b00001 << idx;
    applyStimulus(m, ~m, tick, 1'b0);
  endtask

  initial begin
    #1 sys_rst_n = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    expect_out("reset", 3, 0, 0, 0);

    press(4, 0);  expect_out("start", 3, 1, 0, 0);
    press(4, 0);  expect_out("pause", 3, 0, 0, 0);
    press(4, 0);  expect_out("resume", 3, 1, 0, 0);

    press(2, 0);  expect_out("reverse_drop", 3, 1, 0, 0);
    press(3, 0);  expect_out("same_drop", 3, 1, 0, 0);
    press(0, 0);  expect_out("up_queued", 3, 1, 0, 1);
    applyStimulus(5'b0, 5'b11111, 1, 0); expect_out("tick_up", 0, 1, 1, 0);
    applyStimulus(5'b0, 5'b11111, 0, 0); expect_out("chg_one_cycle", 0, 1, 0, 0);
    press(3, 0);  applyStimulus(5'b0, 5'b11111, 1, 0); expect_out("back_right", 3, 1, 1, 0);

    press(0, 0);  expect_out("fill1", 3, 1, 0, 1);
    press(2, 0);  expect_out("fill2", 3, 1, 0, 2);
    press(1, 0);  expect_out("overflow_drop", 3, 1, 0, 2);
    applyStimulus(5'b0, 5'b11111, 1, 0); expect_out("drain1", 0, 1, 1, 1);
    applyStimulus(5'b0, 5'b11111, 1, 0); expect_out("drain2", 2, 1, 1, 0);
    press(0, 0);  applyStimulus(5'b0, 5'b11111, 1, 0);
    press(3, 0);  applyStimulus(5'b0, 5'b11111, 1, 0); expect_out("right_again", 3, 1, 1, 0);

    applyStimulus(5'b00011, 5'b11100, 0, 0); expect_out("multi_press", 3, 1, 0, 1);
    press(1, 1);  expect_out("tick_reject_down", 0, 1, 1, 0);
    applyStimulus(5'b00001, 5'b11111, 0, 0); expect_out("release_ignored", 0, 1, 0, 0);

    press(2, 0);  press(1, 0); expect_out("full_again", 0, 1, 0, 2);
    press(3, 1);  expect_out("full_tick_push", 2, 1, 1, 2);
    applyStimulus(5'b0, 5'b11111, 1, 0); expect_out("pop_down", 1, 1, 1, 1);
    applyStimulus(5'b0, 5'b11111, 1, 0); expect_out("pop_right", 3, 1, 1, 0);
    press(0, 1);  expect_out("empty_tick_push", 3, 1, 0, 1);
    applyStimulus(5'b0, 5'b11111, 1, 0); expect_out("late_apply", 0, 1, 1, 0);

    press(2, 0);  expect_out("pre_over", 0, 1, 0, 1);
    applyStimulus(5'b10000, 5'b01111, 0, 1); expect_out("over_beats_start", 0, 0, 0, 1);
    applyStimulus(5'b0, 5'b11111, 1, 0); expect_out("over_tick_ignored", 0, 0, 0, 1);
    press(0, 0);  expect_out("over_press_ignored", 0, 0, 0, 1);
    press(4, 0);  expect_out("over_to_idle", 3, 0, 0, 0);
    press(0, 0);  expect_out("idle_press_ignored", 3, 0, 0, 0);

    press(4, 0);  press(0, 0); expect_out("run_q1", 3, 1, 0, 1);
    applyStimulus(5'b10000, 5'b01111, 1, 0); expect_out("pause_beats_tick", 3, 0, 0, 1);
    applyStimulus(5'b0, 5'b11111, 1, 0); expect_out("pause_tick_ignored", 3, 0, 0, 1);
    press(2, 0);  expect_out("pause_press_ignored", 3, 0, 0, 1);
    applyStimulus(5'b0, 5'b11111, 0, 1); expect_out("pause_over", 3, 0, 0, 1);
    press(4, 0);  press(4, 0); expect_out("restart", 3, 1, 0, 0);

    press(0, 0);  press(2, 0); expect_out("pre_reset", 3, 1, 0, 2);
    @(posedge sys_clk);
    #3 sys_rst_n = 1'b0;
    #1 expect_out("async_reset", 3, 0, 0, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    applyStimulus(5'b0, 5'b11111, 1, 0); expect_out("post_reset", 3, 0, 0, 0);

    $display("[TB] == %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
